// File: rtl/period_accumulator_if.sv
`default_nettype none
// ============================================================================
// period_accumulator_if
// Result bus of the period accumulator: summed durations with valid/ready.
// Rev 1.0
// ============================================================================
interface period_accumulator_if #(
  parameter int SW = 28
);
  logic [SW-1:0] sum_p;
  logic [SW-1:0] sum_m;
  logic          res_valid;
  logic          res_ready;

  modport master (
    output sum_p,
    output sum_m,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  sum_p,
    input  sum_m,
    input  res_valid,
    output res_ready
  );
endinterface
`default_nettype wire

// File: rtl/period_accumulator.sv
`default_nettype none
// ============================================================================
// period_accumulator
// Sums 2^ACC_SHIFT high/low duration pairs per result; flags lost signal
// (timeout) and dropped, unread results (overrun).
// Rev 1.0
// ============================================================================
module period_accumulator #(
  parameter int          CW        = 24,
  parameter int          ACC_SHIFT = 4,
  parameter int          SETTLE    = 3,
  parameter int unsigned TIMEOUT   = 24'd12000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cnt,
  input  logic                en,
  input  logic [CW-1:0]       count_p,
  input  logic [CW-1:0]       count_m,
  input  logic                clr,
  period_accumulator_if.master res,
  output logic                overrun,
  output logic                no_signal
);

  localparam int SW  = CW + ACC_SHIFT;
  localparam int PW  = ACC_SHIFT + 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int STW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  localparam logic [PW-1:0]  PER_FULL = PW'(2 ** ACC_SHIFT);
  localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [STW-1:0] SETTLE_V = STW'(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DISCARD = 3'd1,
    S_WAIT    = 3'd2,
    S_SETTLE  = 3'd3,
    S_SAMPLE  = 3'd4,
    S_PUBLISH = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     sync_q, sync_d;
  logic [STW-1:0] settle_q, settle_d;
  logic [PW-1:0]  per_q, per_d, per_inc;
  logic [TW-1:0]  to_q, to_d;
  logic [SW-1:0]  acc_p_q, acc_p_d;
  logic [SW-1:0]  acc_m_q, acc_m_d;
  logic [SW-1:0]  sum_p_q, sum_p_d;
  logic [SW-1:0]  sum_m_q, sum_m_d;
  logic           res_valid_q, res_valid_d;
  logic           overrun_q, overrun_d;
  logic           no_signal_q, no_signal_d;
  logic           fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      settle_q    <= '0;
      per_q       <= '0;
      to_q        <= '0;
      acc_p_q     <= '0;
      acc_m_q     <= '0;
      sum_p_q     <= '0;
      sum_m_q     <= '0;
      res_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      no_signal_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      settle_q    <= settle_d;
      per_q       <= per_d;
      to_q        <= to_d;
      acc_p_q     <= acc_p_d;
      acc_m_q     <= acc_m_d;
      sum_p_q     <= sum_p_d;
      sum_m_q     <= sum_m_d;
      res_valid_q <= res_valid_d;
      overrun_q   <= overrun_d;
      no_signal_q <= no_signal_d;
    end
  end

  // Period end: the counter has just latched count_p; count_m is the low time before it.
  assign fall = sync_q[2] & ~sync_q[1];

  always_comb begin
    sync_d      = {sync_q[1:0], cnt};
    state_d     = state_q;
    settle_d    = settle_q;
    per_d       = per_q;
    per_inc     = per_q + PW'(1);
    to_d        = to_q;
    acc_p_d     = acc_p_q;
    acc_m_d     = acc_m_q;
    sum_p_d     = sum_p_q;
    sum_m_d     = sum_m_q;
    res_valid_d = res_valid_q & ~res.res_ready;
    overrun_d   = overrun_q;
    no_signal_d = no_signal_q;

    // Clear first so that a set condition later in this block wins.
    if (clr) begin
      overrun_d   = 1'b0;
      no_signal_d = 1'b0;
    end

    if (!en) begin
      state_d = S_IDLE;
      acc_p_d = '0;
      acc_m_d = '0;
      per_d   = '0;
      to_d    = '0;
    end else if (state_q != S_IDLE && !fall && to_q == TO_LAST) begin
      no_signal_d = 1'b1;
      acc_p_d     = '0;
      acc_m_d     = '0;
      per_d       = '0;
      to_d        = '0;
      state_d     = S_DISCARD;
    end else begin
      if (state_q != S_IDLE) begin
        to_d = fall ? '0 : to_q + TW'(1);
      end
      if (fall) begin
        no_signal_d = 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          state_d = S_DISCARD;
        end
        S_DISCARD: begin
          if (fall) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (fall) begin
            settle_d = SETTLE_V;
            state_d  = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_q <= STW'(1)) begin
            settle_d = '0;
            state_d  = S_SAMPLE;
          end else begin
            settle_d = settle_q - STW'(1);
          end
        end
        S_SAMPLE: begin
          acc_p_d = acc_p_q + SW'(count_p);
          acc_m_d = acc_m_q + SW'(count_m);
          per_d   = per_inc;
          state_d = (per_inc == PER_FULL) ? S_PUBLISH : S_WAIT;
        end
        S_PUBLISH: begin
          if (!res_valid_q || res.res_ready) begin
            sum_p_d     = acc_p_q;
            sum_m_d     = acc_m_q;
            res_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
          acc_p_d = '0;
          acc_m_d = '0;
          per_d   = '0;
          state_d = S_WAIT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign res.sum_p     = sum_p_q;
  assign res.sum_m     = sum_m_q;
  assign res.res_valid = res_valid_q;
  assign overrun       = overrun_q;
  assign no_signal     = no_signal_q;

endmodule
`default_nettype wire
